aw_rr_arbiter: RTL
==================

// Module: aw_rr_arbiter
// PURPOSE
//  Round-robin scheduler sharing one AW clock-domain-crossing FIFO (push side) between NUM_M masters.
//  Each master presents a packed AW word; the arbiter grants one per cycle and pushes it into the FIFO.
//  It also records grant order in a W-order queue, so the W-channel mux routes write data in AW order.
//  Sits in the master clock domain, between master AW ports and the FIFO's wpush/wdata/wfull.
// PARAMETERS
//  NUM_M      2   number of requesting masters (2..4)
//  DW         45  AW word width: BURST[1:0] SIZE[4:2] LEN[8:5] ADDR[40:9] ID[44:41]
//  MAX_OUTST  4   W-order queue depth = max AW accepted whose W burst is not yet done (power of 2)
// PORTS
//  clk           in   1             single clock
//  rstn          in   1             async reset, active low
//  m_awvalid     in   NUM_M         per-master AW request
//  m_awdata      in   NUM_M*DW      per-master packed AW word, master i at [i*DW +: DW]
//  m_awready     out  NUM_M         per-master accept, one-hot or zero
//  fifo_wpush    out  1             push to AW FIFO
//  fifo_wdata    out  DW            word pushed (granted master's m_awdata)
//  fifo_wfull    in   1             AW FIFO full
//  w_sel         out  clog2(NUM_M)  master index owning the current W burst (queue head)
//  w_sel_valid   out  1             W-order queue non-empty
//  w_last_done   in   1             pulse: WLAST handshake completed for the w_sel master
//  outst_cnt     out  clog2(MAX_OUTST)+1  queue occupancy
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is asynchronous and active-low. All state is cleared by rstn=0.
//  - Reset values: m_awready=0, fifo_wpush=0, fifo_wdata=0, w_sel=0, w_sel_valid=0, outst_cnt=0, prio_ptr=0.
//  - Grant is combinational from registered state. can_grant = !fifo_wfull && (outst_cnt != MAX_OUTST).
//  - The search starts at prio_ptr and wraps modulo NUM_M. g = first i with m_awvalid[i].
//    If can_grant and any valid: m_awready[g]=1, fifo_wpush=1, fifo_wdata=m_awdata[g]. Else all zero.
//  - Handshake: a transfer happens in the same cycle as m_awvalid[g]&m_awready[g], with zero latency.
//    The master must hold valid/data stable until accepted. Unselected masters see ready=0.
//  - After a transfer: prio_ptr <= (g+1) mod NUM_M. With no transfer, prio_ptr holds.
//    A master waits at most NUM_M-1 grants.
//  - W-order queue: circular buffer of MAX_OUTST entries x clog2(NUM_M) bits.
//    Each pointer is clog2(MAX_OUTST)+1 bits wide, with a wrap bit.
//    A transfer writes g at wr_ptr and increments it.
//    w_last_done with w_sel_valid=1 increments rd_ptr.
//    w_last_done while empty is ignored and does not change outst_cnt.
//  - w_sel = entry[rd_ptr], or 0 when empty. w_sel_valid = (wr_ptr != rd_ptr). outst_cnt = wr_ptr - rd_ptr.
//  - Simultaneous push and pop: both pointers advance and outst_cnt is unchanged.
//    A pop never frees a slot for a same-cycle grant (full is checked on registered count).
//  - Full: outst_cnt==MAX_OUTST blocks all grants even if fifo_wfull=0. Empty: w_sel_valid=0.
//  - fifo_wfull=1 blocks all grants; the queue still drains on w_last_done.
//  - Reset mid-operation: the queue is discarded, pointers and prio_ptr return to 0, and outputs drop at once.
//  - No combinational path from fifo_wpush back to m_awvalid. DW is passed through unaltered; no field is modified.
// TESTING
//  1. Reset: rstn=0 with m_awvalid=2'b11 -> m_awready=0, fifo_wpush=0, w_sel_valid=0, outst_cnt=0.
//  2. Fairness: both valid continuously, w_last_done each cycle.
//     Grants alternate M0,M1,M0,M1; fifo_wdata matches each master's word.
//  3. Backpressure: fifo_wfull=1 for 3 cycles with M1 valid -> no push.
//     Deassert wfull -> M1 pushed that cycle, outst_cnt=1.
//  4. Queue full: 4 grants with no w_last_done -> outst_cnt=4 and a 5th request stalls.
//     One w_last_done -> grant resumes next cycle.
//  5. Order: grant M1, M0, M1 -> w_sel sequence 1,0,1 on successive w_last_done.
//     Simultaneous grant+done keeps outst_cnt constant.
//  6. Spurious w_last_done while empty -> no change. Reset asserted with outst_cnt=3 -> all cleared asynchronously.

Source files
------------

// File: rtl/aw_rr_arbiter.sv
// rtl/aw_rr_arbiter.sv - round-robin AW arbiter feeding one AW FIFO, with W-order queue
// Grants one master per cycle into the FIFO and remembers grant order so W data follows AW order.
module aw_rr_arbiter #(
  parameter int NUM_M     = 2,
  parameter int DW        = 45,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_M-1:0]              m_awvalid,
  input  logic [NUM_M*DW-1:0]           m_awdata,
  output logic [NUM_M-1:0]              m_awready,
  output logic                          fifo_wpush,
  output logic [DW-1:0]                 fifo_wdata,
  input  logic                          fifo_wfull,
  output logic [$clog2(NUM_M)-1:0]      w_sel,
  output logic                          w_sel_valid,
  input  logic                          w_last_done,
  output logic [$clog2(MAX_OUTST):0]    outst_cnt
);

  localparam int SW = $clog2(NUM_M);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  logic [SW-1:0] r_prio;
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [SW-1:0] r_q [MAX_OUTST];

  logic [DW-1:0] w_words [NUM_M];
  logic [SW-1:0] w_g;
  logic          w_found;
  logic          w_full;
  logic          w_grant;
  logic          w_pop;
  logic [CW-1:0] w_cnt;

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
    assign w_words[gi] = m_awdata[gi*DW +: DW];
  end

  // First valid master at or after the priority pointer, wrapping modulo NUM_M.
  always_comb begin
    logic [SW:0] sum;
    logic [SW-1:0] idx;
    w_found = 1'b0;
    w_g     = '0;
    for (int k = 0; k < NUM_M; k++) begin
      sum = {1'b0, r_prio} + (SW+1)'(k);
      if (sum >= (SW+1)'(NUM_M)) sum = sum - (SW+1)'(NUM_M);
      idx = sum[SW-1:0];
      if (!w_found && m_awvalid[idx]) begin
        w_found = 1'b1;
        w_g     = idx;
      end
    end
  end

  assign w_cnt       = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_cnt == CW'(MAX_OUTST));
  // rstn gates the grant so outputs drop immediately while reset is held.
  assign w_grant     = rstn && !fifo_wfull && !w_full && w_found;
  assign w_sel_valid = (r_wr_ptr != r_rd_ptr);
  assign w_pop       = w_last_done && w_sel_valid;

  assign m_awready   = w_grant ? (NUM_M'(1) << w_g) : '0;
  assign fifo_wpush  = w_grant;
  assign fifo_wdata  = w_grant ? w_words[w_g] : '0;
  assign w_sel       = w_sel_valid ? r_q[r_rd_ptr[PW-1:0]] : '0;
  assign outst_cnt   = w_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prio   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < MAX_OUTST; i++) r_q[i] <= '0;
    end else begin
      if (w_grant) begin
        r_q[r_wr_ptr[PW-1:0]] <= w_g;
        r_wr_ptr              <= r_wr_ptr + CW'(1);
        r_prio                <= (w_g == SW'(NUM_M-1)) ? '0 : w_g + SW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

endmodule
